mixer_tune_controller: RTL and testbench



---
 rtl/mixer_tune_controller.sv | 162 ++++++++++++++++
 tb/tb_mixer_tune_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_tune_controller.sv
// Retune sequencer: blanks the mixer, moves the NCO phase increment to a new target, settles, unmutes.
// Optional macro TUNE_RAMP_EN: slew phase_inc by at most RAMP_STEP per cycle instead of jumping.
module mixer_tune_controller #(
    parameter int unsigned                   PHASE_WIDTH   = 32,
    parameter logic [PHASE_WIDTH-1:0]        RAMP_STEP     = PHASE_WIDTH'(32'h0001_0000),
    parameter int unsigned                   BLANK_CYCLES  = 4,
    parameter int unsigned                   SETTLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    input  logic [PHASE_WIDTH-1:0] i_req_inc,
    output logic                   o_req_ready,
    output logic [PHASE_WIDTH-1:0] o_phase_inc,
    output logic                   o_mix_enable,
    output logic                   o_busy,
    output logic                   o_tune_done
);

    localparam int unsigned CNT_MAX = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("BLANK_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_chk_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (RAMP_STEP == '0) begin : g_chk_step
        $error("RAMP_STEP must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_SETTLE = 2'd2
`ifdef TUNE_RAMP_EN
        ,
        S_RAMP   = 2'd3
`endif
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [PHASE_WIDTH-1:0] r_target;
    logic [PHASE_WIDTH-1:0] w_target_nxt;
    logic [PHASE_WIDTH-1:0] r_phase_inc;
    logic [PHASE_WIDTH-1:0] w_phase_nxt;
    logic                   r_mix_enable;
    logic                   w_mix_nxt;
    logic                   r_tune_done;
    logic                   w_done_nxt;
    logic                   r_req_ready;
    logic                   r_busy;

`ifdef TUNE_RAMP_EN
    logic                   w_up;
    logic [PHASE_WIDTH:0]   w_diff;

    // Magnitude of the remaining distance, one bit wider so it can never wrap.
    always_comb begin
        w_up   = (r_target >= r_phase_inc);
        w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_phase_inc})
                      : ({1'b0, r_phase_inc} - {1'b0, r_target});
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_phase_nxt  = r_phase_inc;
        w_mix_nxt    = r_mix_enable;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_target_nxt = i_req_inc;
                    w_mix_nxt    = 1'b0;
                    w_cnt_nxt    = CNT_W'(BLANK_CYCLES - 1);
                    w_state_nxt  = S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_cnt == '0) begin
`ifdef TUNE_RAMP_EN
                    w_state_nxt = S_RAMP;
`else
                    w_phase_nxt = r_target;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    w_state_nxt = S_SETTLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
`ifdef TUNE_RAMP_EN
            S_RAMP: begin
                if (w_diff <= {1'b0, RAMP_STEP}) begin
                    w_phase_nxt = r_target;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    w_state_nxt = S_SETTLE;
                end else if (w_up) begin
                    w_phase_nxt = r_phase_inc + RAMP_STEP;
                end else begin
                    w_phase_nxt = r_phase_inc - RAMP_STEP;
                end
            end
`endif
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_mix_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and handshake flags registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_target     <= '0;
            r_phase_inc  <= '0;
            r_mix_enable <= 1'b0;
            r_tune_done  <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_target     <= w_target_nxt;
            r_phase_inc  <= w_phase_nxt;
            r_mix_enable <= w_mix_nxt;
            r_tune_done  <= w_done_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_busy       = r_busy;
    assign o_phase_inc  = r_phase_inc;
    assign o_mix_enable = r_mix_enable;
    assign o_tune_done  = r_tune_done;

endmodule

// File: tb/tb_mixer_tune_controller.sv
// Scoreboard bench for mixer_tune_controller; expectations follow TUNE_RAMP_EN when defined.
module tb_mixer_tune_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_inc;
    logic        o_req_ready;
    logic [31:0] o_phase_inc;
    logic        o_mix_enable;
    logic        o_busy;
    logic        o_tune_done;

    mixer_tune_controller dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_inc    (i_req_inc),
        .o_req_ready  (o_req_ready),
        .o_phase_inc  (o_phase_inc),
        .o_mix_enable (o_mix_enable),
        .o_busy       (o_busy),
        .o_tune_done  (o_tune_done)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_MIXOFF = 0, EV_PHASE = 1, EV_DONE = 2} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t         q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_phase = 32'h0;
    logic        last_mix = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_e kind, input int c, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        q.push_back(e);
    endtask

    // Pop the next expected event and compare it with what the DUT just presented.
    task automatic match(input ev_kind_e kind, input logic [31:0] val);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, expected none",
                     kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%h, expected kind=%0d cyc=%0d val=%h",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (last_mix && !o_mix_enable) match(EV_MIXOFF, 32'h0);
            if (!last_mix && o_mix_enable && !o_tune_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL mix_rise: got mix_enable=1 without tune_done at cycle %0d, expected 0", cyc);
            end
            if (o_phase_inc != last_phase) match(EV_PHASE, o_phase_inc);
            if (o_tune_done) begin
                match(EV_DONE, 32'h0);
                check("done_mix_enable", 64'(o_mix_enable), 64'd1);
                check("done_req_ready", 64'(o_req_ready), 64'd1);
            end
            last_mix   = o_mix_enable;
            last_phase = o_phase_inc;
        end
    end

    // Called at a quiet point; returns the handshake edge number or -1 on timeout.
    task automatic handshake(input logic [31:0] v, output int k);
        i_req_valid = 1'b1;
        i_req_inc   = v;
        k = -1;
        for (int i = 0; i < 200; i++) begin
            if (o_req_ready) begin
                k = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (k < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no req_ready, expected acceptance of %h", v);
        end
    endtask

    task automatic release_req();
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending events, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] ph);
        check({tag, "_phase_inc"}, 64'(o_phase_inc), 64'(ph));
        check({tag, "_mix_enable"}, 64'(o_mix_enable), 64'd0);
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_tune_done"}, 64'(o_tune_done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int k2;
        int rst_edge;
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_req_inc   = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset", 32'h0);
        mon_en = 1'b1;
        repeat (50) @(negedge clk);
        check_idle_outputs("idle50", 32'h0);

        // 0 -> 0x40000
        handshake(32'h0004_0000, k);
`ifdef TUNE_RAMP_EN
        push(EV_PHASE, k + 5, 32'h0001_0000);
        push(EV_PHASE, k + 6, 32'h0002_0000);
        push(EV_PHASE, k + 7, 32'h0003_0000);
        push(EV_PHASE, k + 8, 32'h0004_0000);
        push(EV_DONE,  k + 24, 32'h0);
`else
        push(EV_PHASE, k + 4, 32'h0004_0000);
        push(EV_DONE,  k + 20, 32'h0);
`endif
        release_req();
        drain();

        // 0x40000 -> 0x18000, partial final step
        handshake(32'h0001_8000, k);
        push(EV_MIXOFF, k, 32'h0);
`ifdef TUNE_RAMP_EN
        push(EV_PHASE, k + 5, 32'h0003_0000);
        push(EV_PHASE, k + 6, 32'h0002_0000);
        push(EV_PHASE, k + 7, 32'h0001_8000);
        push(EV_DONE,  k + 23, 32'h0);
`else
        push(EV_PHASE, k + 4, 32'h0001_8000);
        push(EV_DONE,  k + 20, 32'h0);
`endif
        release_req();
        drain();

        // Request equal to the current increment
        handshake(32'h0001_8000, k);
        push(EV_MIXOFF, k, 32'h0);
`ifdef TUNE_RAMP_EN
        push(EV_DONE, k + 21, 32'h0);
`else
        push(EV_DONE, k + 20, 32'h0);
`endif
        release_req();
        drain();

        // Back-to-back: second request held valid while busy
        handshake(32'h0003_8000, k);
        push(EV_MIXOFF, k, 32'h0);
`ifdef TUNE_RAMP_EN
        push(EV_PHASE, k + 5, 32'h0002_8000);
        push(EV_PHASE, k + 6, 32'h0003_8000);
        push(EV_DONE,  k + 22, 32'h0);
`else
        push(EV_PHASE, k + 4, 32'h0003_8000);
        push(EV_DONE,  k + 20, 32'h0);
`endif
        @(posedge clk);
        #1 i_req_inc = 32'h0003_0000;
        for (int i = 0; i < 20 && cyc < k + 10; i++) @(negedge clk);
        check("b2b_busy_ready", 64'(o_req_ready), 64'd0);
        check("b2b_busy_busy", 64'(o_busy), 64'd1);
        handshake(32'h0003_0000, k2);
`ifdef TUNE_RAMP_EN
        check("b2b_accept_edge", 64'(k2), 64'(k + 23));
        push(EV_MIXOFF, k2, 32'h0);
        push(EV_PHASE, k2 + 5, 32'h0003_0000);
        push(EV_DONE,  k2 + 21, 32'h0);
`else
        check("b2b_accept_edge", 64'(k2), 64'(k + 21));
        push(EV_MIXOFF, k2, 32'h0);
        push(EV_PHASE, k2 + 4, 32'h0003_0000);
        push(EV_DONE,  k2 + 20, 32'h0);
`endif
        release_req();
        drain();

        // Reset in the middle of a retune
        handshake(32'h0008_0000, k);
        push(EV_MIXOFF, k, 32'h0);
`ifdef TUNE_RAMP_EN
        push(EV_PHASE, k + 5, 32'h0004_0000);
        push(EV_PHASE, k + 6, 32'h0005_0000);
        rst_edge = k + 7;
`else
        push(EV_PHASE, k + 4, 32'h0008_0000);
        rst_edge = k + 6;
`endif
        push(EV_PHASE, rst_edge, 32'h0);
        release_req();
        for (int i = 0; i < 50 && cyc < rst_edge - 1; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset", 32'h0);
        repeat (30) @(negedge clk);
        drain();

        // Normal retune after the mid-sequence reset
        handshake(32'h0001_0000, k);
`ifdef TUNE_RAMP_EN
        push(EV_PHASE, k + 5, 32'h0001_0000);
        push(EV_DONE,  k + 21, 32'h0);
`else
        push(EV_PHASE, k + 4, 32'h0001_0000);
        push(EV_DONE,  k + 20, 32'h0);
`endif
        release_req();
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
